// File: rtl/mem_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared encodings for the memory-access stage: access size
//                codes, FSM state encodings, byte-enable lookup constants and
//                helper functions for alignment and lane selection.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    // MemSize encodings
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } mem_size_e;

    // Stage FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    // Byte-enable lookup constants
    localparam logic [3:0] c_be_byte0   = 4'b0001;
    localparam logic [3:0] c_be_half_lo = 4'b0011;
    localparam logic [3:0] c_be_half_hi = 4'b1100;
    localparam logic [3:0] c_be_word    = 4'b1111;

    // Size 11 is never legal; half needs even, word needs 4-byte alignment.
    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] addr);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = c_be_byte0 << addr;
            SZ_HALF: be = addr[1] ? c_be_half_hi : c_be_half_lo;
            default: be = c_be_word;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : load_aligner
//  Description : Combinational load lane select and extension. Picks the
//                byte/half addressed by addr[1:0] out of the read word and
//                sign- or zero-extends it to 32 bits; words pass unchanged.
//  Ports       : rdata     - read word from memory
//                addr      - byte offset within the word
//                size      - access size (byte/half/word)
//                is_signed - 1 sign-extend, 0 zero-extend
//                data      - extended load result
//  Revision    : 1.0  initial release
// ============================================================================
module load_aligner
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        // Two-level mux: addr[1] picks the half, addr[0] the byte within it.
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
        w_byte = addr[0] ? w_half[15:8] : w_half[7:0];
        case (size)
            SZ_BYTE: data = {{24{is_signed & w_byte[7]}}, w_byte};
            SZ_HALF: data = {{16{is_signed & w_half[15]}}, w_half};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : Pipeline memory stage. Loads/stores byte, half or word over
//                a req/ack bus, stalls upstream while an access is in flight,
//                aborts unacknowledged accesses after TIMEOUT cycles, and
//                passes non-memory results straight through.
//  Ports       : clk, rst_n                 - clock, sync active-low reset
//                valid_in, ALUResult,
//                WriteData, MemRead,
//                MemWrite, MemSize,
//                MemSigned                  - operation from Execute
//                stall                      - hold upstream (combinational)
//                valid_out, ReadData,
//                misaligned, bus_error      - registered result to writeback
//                mem_req, mem_we, mem_addr,
//                mem_wdata, mem_be,
//                mem_ack, mem_rdata         - data-memory handshake
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] ReadData,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic             c_wd_en    = (TIMEOUT != 0);
    // Abort fires at the end of the TIMEOUT-th ACCESS cycle.
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_e           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [1:0]       r_lane, w_lane_nx;
    logic [1:0]       r_size, w_size_nx;
    logic             r_signed, w_signed_nx;

    logic             w_valid_nx, w_mis_nx, w_berr_nx, w_req_nx, w_we_nx;
    logic [31:0]      w_rdata_nx, w_addr_nx, w_wdata_nx;
    logic [3:0]       w_be_nx;

    logic             w_mem_op, w_misalign, w_accept, w_timeout;
    logic [31:0]      w_load, w_store_data;

    assign w_mem_op   = MemRead | MemWrite;
    assign w_misalign = size_misaligned(MemSize, ALUResult[1:0]);
    assign w_accept   = (r_state == ST_IDLE) && valid_in && w_mem_op && !w_misalign;
    assign w_timeout  = c_wd_en && (r_cnt == c_cnt_last);

    // Stall rises in the accept cycle itself and holds through RESP.
    assign stall = w_accept || (r_state != ST_IDLE);

    load_aligner u_load_aligner (
        .rdata     (mem_rdata),
        .addr      (r_lane),
        .size      (r_size),
        .is_signed (r_signed),
        .data      (w_load)
    );

    // Store data replicated across every lane the byte enables may select.
    always_comb begin
        case (MemSize)
            SZ_BYTE: w_store_data = {4{WriteData[7:0]}};
            SZ_HALF: w_store_data = {2{WriteData[15:0]}};
            default: w_store_data = WriteData;
        endcase
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_lane_nx   = r_lane;
        w_size_nx   = r_size;
        w_signed_nx = r_signed;
        w_valid_nx  = 1'b0;
        w_rdata_nx  = '0;
        w_mis_nx    = 1'b0;
        w_berr_nx   = 1'b0;
        w_req_nx    = mem_req;
        w_we_nx     = mem_we;
        w_addr_nx   = mem_addr;
        w_wdata_nx  = mem_wdata;
        w_be_nx     = mem_be;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (valid_in) begin
                    if (!w_mem_op) begin
                        w_valid_nx = 1'b1;
                        w_rdata_nx = ALUResult;
                    end else if (w_misalign) begin
                        w_valid_nx = 1'b1;
                        w_mis_nx   = 1'b1;
                    end else begin
                        w_state_nx  = ST_ACCESS;
                        w_req_nx    = 1'b1;
                        w_we_nx     = MemWrite;   // write wins when both set
                        w_addr_nx   = {ALUResult[31:2], 2'b00};
                        w_be_nx     = byte_enable(MemSize, ALUResult[1:0]);
                        w_wdata_nx  = w_store_data;
                        w_lane_nx   = ALUResult[1:0];
                        w_size_nx   = MemSize;
                        w_signed_nx = MemSigned;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is checked first so it wins over a same-cycle timeout.
                if (mem_ack) begin
                    w_state_nx = ST_RESP;
                    w_req_nx   = 1'b0;
                    w_valid_nx = 1'b1;
                    w_rdata_nx = mem_we ? 32'd0 : w_load;
                    w_cnt_nx   = '0;
                end else if (w_timeout) begin
                    w_state_nx = ST_RESP;
                    w_req_nx   = 1'b0;
                    w_valid_nx = 1'b1;
                    w_berr_nx  = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_req_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_lane     <= '0;
            r_size     <= '0;
            r_signed   <= 1'b0;
            valid_out  <= 1'b0;
            ReadData   <= '0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_lane     <= w_lane_nx;
            r_size     <= w_size_nx;
            r_signed   <= w_signed_nx;
            valid_out  <= w_valid_nx;
            ReadData   <= w_rdata_nx;
            misaligned <= w_mis_nx;
            bus_error  <= w_berr_nx;
            mem_req    <= w_req_nx;
            mem_we     <= w_we_nx;
            mem_addr   <= w_addr_nx;
            mem_wdata  <= w_wdata_nx;
            mem_be     <= w_be_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_stage
//  Description : Scoreboard testbench for mem_access_stage. Stimulus pushes
//                expected bus requests and expected results into queues; a
//                memory responder and an output monitor pop and compare.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] ALUResult, WriteData;
    logic        MemRead, MemWrite, MemSigned;
    logic [1:0]  MemSize;
    logic        stall, valid_out, misaligned, bus_error;
    logic [31:0] ReadData;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          chk_tmo;
    } req_t;

    resp_t exp_q[$];
    req_t  req_q[$];

    int total = 0;
    int bad   = 0;
    bit stray_ack = 1'b0;

    mem_access_stage #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .stall     (stall),
        .valid_out (valid_out),
        .ReadData  (ReadData),
        .misaligned(misaligned),
        .bus_error (bus_error),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one operation starting at posedge+1 with the stage idle; returns
    // at posedge+1 with the stage idle again.
    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int delay);
        bit          memop, mis, accepted;
        int          lane, n, exp_stall;
        resp_t       r;
        req_t        q;
        logic [31:0] v;
        memop = rd || wr;
        lane  = int'(a % 4);
        mis   = memop && (sz == 2'd3 || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && lane != 0));
        accepted = memop && !mis;
        r.data = 32'd0; r.mis = 1'b0; r.berr = 1'b0;
        if (!memop) begin
            r.data = a;
        end else if (mis) begin
            r.mis = 1'b1;
        end else begin
            q.we    = wr;
            q.addr  = a - 32'(lane);
            q.rdata = rdat;
            q.delay = delay;
            q.chk_tmo = (delay >= TMO);
            case (sz)
                2'd0: begin q.be = 4'(1 << lane); q.wdata = (wd & 32'hFF)   * 32'h01010101; end
                2'd1: begin q.be = 4'(3 << lane); q.wdata = (wd & 32'hFFFF) * 32'h00010001; end
                default: begin q.be = 4'hF; q.wdata = wd; end
            endcase
            if (delay >= TMO) begin
                r.berr = 1'b1;
            end else if (!wr) begin
                case (sz)
                    2'd0: begin
                        v = (rdat >> (8 * lane)) & 32'hFF;
                        if (sg && v >= 32'd128) v = v - 32'd256;
                    end
                    2'd1: begin
                        v = (rdat >> (8 * lane)) & 32'hFFFF;
                        if (sg && v >= 32'd32768) v = v - 32'd65536;
                    end
                    default: v = rdat;
                endcase
                r.data = v;
            end
            req_q.push_back(q);
        end
        exp_q.push_back(r);

        ALUResult = a; WriteData = wd; MemRead = rd; MemWrite = wr;
        MemSize = sz; MemSigned = sg; valid_in = 1'b1;
        @(negedge clk);
        check("stall_at_issue", 32'(stall), 32'(accepted));
        @(posedge clk); #1;
        valid_in = 1'b0;
        if (accepted) begin
            exp_stall = (delay >= TMO) ? TMO + 2 : delay + 3;
            n = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (stall) n++;
                else break;
            end
            check("stall_cycles", 32'(n), 32'(exp_stall));
            @(posedge clk); #1;
        end
    endtask

    // Memory responder: checks each request against the expected queue and
    // acknowledges after the requested number of extra cycles.
    req_t cur;
    bit   busy = 1'b0;
    int   wc = 0, reqcyc = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = stray_ack;
            if (!mem_req) begin
                if (busy && cur.chk_tmo) check("req_cycles_before_abort", 32'(reqcyc), 32'(TMO));
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1; wc = 0; reqcyc = 0;
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", mem_addr);
                        cur.we = mem_we; cur.addr = mem_addr; cur.be = mem_be;
                        cur.wdata = mem_wdata; cur.rdata = 32'd0; cur.delay = 1000; cur.chk_tmo = 1'b0;
                    end else begin
                        cur = req_q.pop_front();
                    end
                end else begin
                    wc++;
                end
                reqcyc++;
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_addr", mem_addr, cur.addr);
                check("mem_be", 32'(mem_be), 32'(cur.be));
                if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                if (wc == cur.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                end else begin
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Output monitor
    resp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid_out) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid_out: got ReadData 0x%08h, expected no result", ReadData);
                end else begin
                    e = exp_q.pop_front();
                    check("ReadData", ReadData, e.data);
                    check("misaligned", 32'(misaligned), 32'(e.mis));
                    check("bus_error", 32'(bus_error), 32'(e.berr));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        req_t        rq;
        bit          rd, wr, sg;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r, d;
        rst_n = 1'b0; valid_in = 1'b0; ALUResult = 0; WriteData = 0;
        MemRead = 0; MemWrite = 0; MemSize = 0; MemSigned = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_mem_req", 32'(mem_req), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_outputs_or", {ReadData | mem_addr | mem_wdata}, 0);
        check("reset_flags", 32'({misaligned, bus_error, mem_we, mem_be}), 0);
        @(posedge clk); #1;

        issue(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 2);        // SW
        issue(0, 1, 2'd0, 0, 32'h21, 32'h000000AB, 32'h0, 1);        // SB
        issue(1, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF1234, 0);        // LB signed
        issue(1, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF1234, 3);        // LBU
        issue(1, 0, 2'd1, 1, 32'h12, 32'h0, 32'hBEEF0000, 1);        // LH
        issue(1, 0, 2'd1, 1, 32'h11, 32'h0, 32'h0, 0);               // LH misaligned
        issue(1, 0, 2'd3, 0, 32'h20, 32'h0, 32'h0, 0);               // illegal size
        issue(0, 1, 2'd2, 0, 32'h22, 32'h12345678, 32'h0, 0);        // SW misaligned
        issue(0, 0, 2'd0, 0, 32'h1, 32'h0, 32'h0, 0);                // pass-through
        issue(0, 0, 2'd2, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
        issue(0, 0, 2'd1, 1, 32'h8000_0003, 32'h0, 32'h0, 0);
        issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h12345678, 1000);     // watchdog abort
        issue(1, 0, 2'd2, 1, 32'h44, 32'h0, 32'hCAFEF00D, TMO - 1);  // ack with timeout
        issue(1, 1, 2'd1, 0, 32'h2, 32'h1234ABCD, 32'h0, 0);         // write wins

        // Reset in the middle of an access
        rq.we = 1'b0; rq.addr = 32'h80; rq.be = 4'hF; rq.wdata = 0;
        rq.rdata = 32'h55AA55AA; rq.delay = 1000; rq.chk_tmo = 1'b0;
        req_q.push_back(rq);
        ALUResult = 32'h80; MemRead = 1; MemWrite = 0; MemSize = 2'd2; MemSigned = 0;
        valid_in = 1'b1;
        @(posedge clk); #1 valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_req", 32'(mem_req), 0);
        check("rst_mid_stall", 32'(stall), 0);
        stray_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_ack_valid_out", 32'(valid_out), 0);
        end
        @(posedge clk); #1 stray_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 4) == 0) begin
                rd = 0; wr = 0;
            end else begin
                r  = $urandom_range(0, 2);
                rd = (r != 1); wr = (r != 0);
            end
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom_range(0, 9);
            issue(rd, wr, sz, sg, a, $urandom, $urandom, d);
        end

        repeat (5) @(negedge clk);
        check("results_pending", 32'(exp_q.size()), 0);
        check("requests_pending", 32'(req_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
